// File: rtl/mcoi_rs485_frame_rx_pkg.sv
// Shared constants and types for the MCOI RS485 diagnostic frame receiver.
package mcoi_rs485_frame_rx_pkg;

    localparam logic [7:0] RS485_SOF = 8'h7E;

    typedef enum logic [2:0] {
        IDLE,
        ID,
        LEN,
        DATA,
        CSUM
    } rs485_rx_state_t;

    typedef enum logic [1:0] {
        U_IDLE,
        U_START,
        U_DATA,
        U_STOP
    } uart_rx_state_t;

    typedef struct packed {
        logic [15:0] overrun;
        logic [15:0] timeout;
        logic [15:0] csum;
        logic [15:0] framing;
    } rs485_stat_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v, input logic en);
        return (en && (v != 16'hFFFF)) ? v + 16'd1 : v;
    endfunction

endpackage

// File: rtl/mcoi_rs485_frame_rx_uart.sv
// 8N1 byte receiver: 2-flop synchroniser, start-bit validation, mid-bit sampling,
// stop-bit check, and an inter-byte idle timer that ticks once per idle gap.
module mcoi_uart_rx_byte
    import mcoi_rs485_frame_rx_pkg::*;
#(
    parameter int BIT_DIV     = 868,
    parameter int TIMEOUT_CYC = 17360
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_i,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    output logic       frame_err_o,
    output logic       idle_tick_o
);

    localparam int CW = (BIT_DIV > 2) ? $clog2(BIT_DIV) : 1;
    localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] HALF_LOAD = CW'(BIT_DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_LOAD = CW'(BIT_DIV - 1);
    localparam logic [TW-1:0] TO_LOAD   = TW'(TIMEOUT_CYC - 1);

    uart_rx_state_t st_q;
    logic           rx_meta_q;
    logic           rx_sync_q;
    logic           rx_prev_q;
    logic [CW-1:0]  cnt_q;
    logic [2:0]     bit_q;
    logic [7:0]     shift_q;
    logic [7:0]     byte_q;
    logic           byte_valid_q;
    logic           frame_err_q;
    logic [TW-1:0]  timer_q;
    logic           timer_run_q;
    logic           tick_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q         <= U_IDLE;
            rx_meta_q    <= 1'b1;
            rx_sync_q    <= 1'b1;
            rx_prev_q    <= 1'b1;
            cnt_q        <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            byte_q       <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            timer_q      <= '0;
            timer_run_q  <= 1'b0;
            tick_q       <= 1'b0;
        end else begin
            rx_meta_q    <= rx_i;
            rx_sync_q    <= rx_meta_q;
            rx_prev_q    <= rx_sync_q;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            tick_q       <= 1'b0;

            case (st_q)
                U_IDLE: begin
                    if (rx_prev_q && !rx_sync_q) begin
                        st_q  <= U_START;
                        cnt_q <= HALF_LOAD;
                    end else if (timer_run_q) begin
                        // One tick per gap; rearmed only by the next stop bit.
                        if (timer_q == '0) begin
                            tick_q      <= 1'b1;
                            timer_run_q <= 1'b0;
                        end else begin
                            timer_q <= timer_q - TW'(1);
                        end
                    end
                end
                U_START: begin
                    timer_run_q <= 1'b0;
                    if (cnt_q == '0) begin
                        if (rx_sync_q) begin
                            st_q <= U_IDLE;
                        end else begin
                            st_q  <= U_DATA;
                            cnt_q <= FULL_LOAD;
                            bit_q <= '0;
                        end
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                U_DATA: begin
                    if (cnt_q == '0) begin
                        shift_q <= {rx_sync_q, shift_q[7:1]};
                        cnt_q   <= FULL_LOAD;
                        if (bit_q == 3'd7) begin
                            st_q <= U_STOP;
                        end else begin
                            bit_q <= bit_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                U_STOP: begin
                    if (cnt_q == '0) begin
                        st_q        <= U_IDLE;
                        timer_q     <= TO_LOAD;
                        timer_run_q <= 1'b1;
                        if (rx_sync_q) begin
                            byte_valid_q <= 1'b1;
                            byte_q       <= shift_q;
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                default: st_q <= U_IDLE;
            endcase
        end
    end

    assign byte_o       = byte_q;
    assign byte_valid_o = byte_valid_q;
    assign frame_err_o  = frame_err_q;
    assign idle_tick_o  = tick_q;

endmodule

// File: rtl/mcoi_rs485_frame_rx.sv
// MCOI RS485 diagnostic frame receiver: SOF/ID/LEN/PAYLOAD/CSUM decode, valid/ack release.
// Statistics counters are built only when MCOI_RS485_RX_STATS_EN is defined.
module mcoi_rs485_frame_rx
    import mcoi_rs485_frame_rx_pkg::*;
#(
    parameter int CLK_FREQ_HZ  = 100_000_000,
    parameter int BAUD_RATE    = 115_200,
    parameter int MAX_PAYLOAD  = 16,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               rs485_rx_i,
    output logic                               frame_valid_o,
    input  logic                               frame_ack_i,
    output logic [7:0]                         frame_id_o,
    output logic [$clog2(MAX_PAYLOAD+1)-1:0]   frame_len_o,
    output logic [8*MAX_PAYLOAD-1:0]           frame_data_o,
    output logic                               err_frame_o,
    output logic                               err_csum_o,
    output logic                               err_len_o,
    output logic                               err_timeout_o,
    output logic                               overrun_o,
    output logic [63:0]                        stat_cnt_o
);

    // state | meaning
    // IDLE  | hunting for SOF; other bytes ignored
    // ID    | next byte is the frame ID
    // LEN   | next byte is payload length, checked against 1..MAX_PAYLOAD
    // DATA  | collecting payload bytes into the working buffer
    // CSUM  | next byte is compared with the running XOR

    localparam int BIT_DIV = CLK_FREQ_HZ / BAUD_RATE;
    localparam int LW      = $clog2(MAX_PAYLOAD + 1);
    localparam int IW      = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
    localparam int DW      = 8 * MAX_PAYLOAD;
    localparam logic [7:0] MAX_LEN = 8'(MAX_PAYLOAD);

    logic [7:0] rx_byte;
    logic       rx_byte_valid;
    logic       rx_frame_err;
    logic       rx_idle_tick;

    mcoi_uart_rx_byte #(
        .BIT_DIV     (BIT_DIV),
        .TIMEOUT_CYC (TIMEOUT_BITS * BIT_DIV)
    ) u_uart (
        .clk          (clk),
        .rst          (rst),
        .rx_i         (rs485_rx_i),
        .byte_o       (rx_byte),
        .byte_valid_o (rx_byte_valid),
        .frame_err_o  (rx_frame_err),
        .idle_tick_o  (rx_idle_tick)
    );

    rs485_rx_state_t state_q;
    logic [7:0]      csum_q;
    logic [7:0]      id_q;
    logic [LW-1:0]   len_q;
    logic [IW-1:0]   idx_q;
    logic [DW-1:0]   wbuf_q;
    logic            frame_valid_q;
    logic [7:0]      frame_id_q;
    logic [LW-1:0]   frame_len_q;
    logic [DW-1:0]   frame_data_q;
    logic            err_frame_q;
    logic            err_csum_q;
    logic            err_len_q;
    logic            err_timeout_q;
    logic            overrun_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            csum_q        <= '0;
            id_q          <= '0;
            len_q         <= '0;
            idx_q         <= '0;
            wbuf_q        <= '0;
            frame_valid_q <= 1'b0;
            frame_id_q    <= '0;
            frame_len_q   <= '0;
            frame_data_q  <= '0;
            err_frame_q   <= 1'b0;
            err_csum_q    <= 1'b0;
            err_len_q     <= 1'b0;
            err_timeout_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            err_frame_q   <= 1'b0;
            err_csum_q    <= 1'b0;
            err_len_q     <= 1'b0;
            err_timeout_q <= 1'b0;
            overrun_q     <= 1'b0;

            if (frame_valid_q && frame_ack_i) begin
                frame_valid_q <= 1'b0;
            end

            if (rx_frame_err) begin
                err_frame_q <= 1'b1;
                state_q     <= IDLE;
            end else if (rx_idle_tick && (state_q != IDLE)) begin
                err_timeout_q <= 1'b1;
                state_q       <= IDLE;
            end else if (rx_byte_valid) begin
                case (state_q)
                    IDLE: begin
                        if (rx_byte == RS485_SOF) begin
                            state_q <= ID;
                        end
                    end
                    ID: begin
                        id_q    <= rx_byte;
                        csum_q  <= rx_byte;
                        state_q <= LEN;
                    end
                    LEN: begin
                        if ((rx_byte == 8'h00) || (rx_byte > MAX_LEN)) begin
                            err_len_q <= 1'b1;
                            state_q   <= IDLE;
                        end else begin
                            len_q   <= LW'(rx_byte);
                            csum_q  <= csum_q ^ rx_byte;
                            idx_q   <= '0;
                            state_q <= DATA;
                        end
                    end
                    DATA: begin
                        for (int k = 0; k < MAX_PAYLOAD; k++) begin
                            if (idx_q == IW'(k)) begin
                                wbuf_q[8*k +: 8] <= rx_byte;
                            end
                        end
                        csum_q <= csum_q ^ rx_byte;
                        idx_q  <= idx_q + IW'(1);
                        if ((LW'(idx_q) + LW'(1)) == len_q) begin
                            state_q <= CSUM;
                        end
                    end
                    CSUM: begin
                        state_q <= IDLE;
                        if (rx_byte != csum_q) begin
                            err_csum_q <= 1'b1;
                        end else if (frame_valid_q) begin
                            // Covers the same-cycle ack: the old frame is cleared, the new one is dropped.
                            overrun_q <= 1'b1;
                        end else begin
                            frame_valid_q <= 1'b1;
                            frame_id_q    <= id_q;
                            frame_len_q   <= len_q;
                            for (int k = 0; k < MAX_PAYLOAD; k++) begin
                                frame_data_q[8*k +: 8] <= (k < int'(len_q)) ? wbuf_q[8*k +: 8] : 8'h00;
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign frame_valid_o = frame_valid_q;
    assign frame_id_o    = frame_id_q;
    assign frame_len_o   = frame_len_q;
    assign frame_data_o  = frame_data_q;
    assign err_frame_o   = err_frame_q;
    assign err_csum_o    = err_csum_q;
    assign err_len_o     = err_len_q;
    assign err_timeout_o = err_timeout_q;
    assign overrun_o     = overrun_q;

`ifdef MCOI_RS485_RX_STATS_EN
    rs485_stat_t stat_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_q <= '0;
        end else begin
            stat_q.overrun <= sat_inc16(stat_q.overrun, overrun_q);
            stat_q.timeout <= sat_inc16(stat_q.timeout, err_timeout_q);
            stat_q.csum    <= sat_inc16(stat_q.csum, err_csum_q);
            stat_q.framing <= sat_inc16(stat_q.framing, err_frame_q);
        end
    end

    assign stat_cnt_o = stat_q;
`else
    assign stat_cnt_o = '0;
`endif

endmodule

// File: tb/tb_mcoi_rs485_frame_rx.sv
// Self-checking bench for mcoi_rs485_frame_rx using a frame-level reference model.
`timescale 1ns/1ps
module tb_mcoi_rs485_frame_rx;

    localparam int MAXP    = 16;
    localparam int LW      = 5;
    localparam int BIT_DIV = 16;
    localparam int BAUD    = 115_200;
    localparam int TOB     = 20;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              rx  = 1'b1;
    logic              ack = 1'b0;
    logic              frame_valid_o;
    logic [7:0]        frame_id_o;
    logic [LW-1:0]     frame_len_o;
    logic [8*MAXP-1:0] frame_data_o;
    logic              err_frame_o, err_csum_o, err_len_o, err_timeout_o, overrun_o;
    logic [63:0]       stat_cnt_o;

    always #5 clk = ~clk;

    mcoi_rs485_frame_rx #(
        .CLK_FREQ_HZ  (BIT_DIV * BAUD),
        .BAUD_RATE    (BAUD),
        .MAX_PAYLOAD  (MAXP),
        .TIMEOUT_BITS (TOB)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rs485_rx_i    (rx),
        .frame_valid_o (frame_valid_o),
        .frame_ack_i   (ack),
        .frame_id_o    (frame_id_o),
        .frame_len_o   (frame_len_o),
        .frame_data_o  (frame_data_o),
        .err_frame_o   (err_frame_o),
        .err_csum_o    (err_csum_o),
        .err_len_o     (err_len_o),
        .err_timeout_o (err_timeout_o),
        .overrun_o     (overrun_o),
        .stat_cnt_o    (stat_cnt_o)
    );

    int n_cmp = 0;
    int n_fail = 0;
    // observed pulse counts, expected pulse counts, expected statistics (cleared by reset)
    int m_fr = 0, m_cs = 0, m_len = 0, m_to = 0, m_ov = 0;
    int e_fr = 0, e_cs = 0, e_len = 0, e_to = 0, e_ov = 0;
    int s_fr = 0, s_cs = 0, s_to = 0, s_ov = 0;
    logic [7:0] pl [MAXP];

    always @(negedge clk) begin
        if (!rst) begin
            if (err_frame_o)   m_fr++;
            if (err_csum_o)    m_cs++;
            if (err_len_o)     m_len++;
            if (err_timeout_o) m_to++;
            if (overrun_o)     m_ov++;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [7:0] model_csum(input logic [7:0] id, input int len);
        logic [7:0] c;
        c = id ^ 8'(len);
        for (int k = 0; k < len; k++) c = c ^ pl[k];
        return c;
    endfunction

    function automatic logic [8*MAXP-1:0] model_data(input int len);
        logic [8*MAXP-1:0] d;
        d = '0;
        for (int k = 0; k < len; k++) d[8*k +: 8] = pl[k];
        return d;
    endfunction

    function automatic logic [63:0] model_stat();
`ifdef MCOI_RS485_RX_STATS_EN
        return {16'(s_ov), 16'(s_to), 16'(s_cs), 16'(s_fr)};
`else
        return 64'h0;
`endif
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        logic [9:0] fr;
        fr = {stop_ok, b, 1'b0};
        @(posedge clk);
        #1;
        for (int i = 0; i < 10; i++) begin
            rx = fr[i];
            repeat (BIT_DIV) @(posedge clk);
            #1;
        end
        rx = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] id, input int len, input bit bad);
        send_byte(8'h7E, 1'b1);
        send_byte(id, 1'b1);
        send_byte(8'(len), 1'b1);
        for (int k = 0; k < len; k++) send_byte(pl[k], 1'b1);
        send_byte(model_csum(id, len) ^ (bad ? 8'h01 : 8'h00), 1'b1);
    endtask

    task automatic fill_random(input int len);
        for (int k = 0; k < len; k++) pl[k] = 8'($urandom);
    endtask

    task automatic wait_valid();
        int w;
        w = 0;
        while (frame_valid_o !== 1'b1 && w < 60) begin
            @(posedge clk);
            #1;
            w++;
        end
    endtask

    task automatic do_ack();
        @(posedge clk);
        #1 ack = 1'b1;
        @(posedge clk);
        #1 ack = 1'b0;
    endtask

    task automatic test_reset();
        idle(3);
        n_cmp++;
        if ({frame_valid_o, frame_id_o, frame_len_o, frame_data_o, err_frame_o, err_csum_o, err_len_o, err_timeout_o, overrun_o, stat_cnt_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got valid=%0b id=%h len=%0d data=%h stat=%h, want all zero", frame_valid_o, frame_id_o, frame_len_o, frame_data_o, stat_cnt_o);
        end
        rst = 1'b0;
        idle(5);
    endtask

    task automatic test_basic();
        pl[0] = 8'hA5;
        pl[1] = 8'h5A;
        send_frame(8'h01, 2, 1'b0);
        wait_valid();
        n_cmp++;
        if (frame_valid_o !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %0b want 1", frame_valid_o); end
        n_cmp++;
        if (frame_id_o !== 8'h01) begin n_fail++; $display("FAIL basic_id: got %h want 01", frame_id_o); end
        n_cmp++;
        if (frame_len_o !== LW'(2)) begin n_fail++; $display("FAIL basic_len: got %0d want 2", frame_len_o); end
        n_cmp++;
        if (frame_data_o !== model_data(2)) begin n_fail++; $display("FAIL basic_data: got %h want %h", frame_data_o, model_data(2)); end
        n_cmp++;
        if ({m_fr, m_cs, m_len, m_to, m_ov} !== {e_fr, e_cs, e_len, e_to, e_ov}) begin
            n_fail++;
            $display("FAIL basic_pulses: got fr=%0d cs=%0d len=%0d to=%0d ov=%0d want %0d %0d %0d %0d %0d", m_fr, m_cs, m_len, m_to, m_ov, e_fr, e_cs, e_len, e_to, e_ov);
        end
        do_ack();
        n_cmp++;
        if (frame_valid_o !== 1'b0) begin n_fail++; $display("FAIL basic_ack_clear: got %0b want 0", frame_valid_o); end
    endtask

    task automatic test_csum();
        pl[0] = 8'hA5;
        pl[1] = 8'h5A;
        send_frame(8'h01, 2, 1'b1);
        e_cs++;
        s_cs++;
        idle(20);
        n_cmp++;
        if (frame_valid_o !== 1'b0) begin n_fail++; $display("FAIL csum_valid: got %0b want 0", frame_valid_o); end
        n_cmp++;
        if ({m_fr, m_cs, m_len, m_to, m_ov} !== {e_fr, e_cs, e_len, e_to, e_ov}) begin
            n_fail++;
            $display("FAIL csum_pulses: got fr=%0d cs=%0d len=%0d to=%0d ov=%0d want %0d %0d %0d %0d %0d", m_fr, m_cs, m_len, m_to, m_ov, e_fr, e_cs, e_len, e_to, e_ov);
        end
        n_cmp++;
        if (stat_cnt_o !== model_stat()) begin n_fail++; $display("FAIL csum_stat: got %h want %h", stat_cnt_o, model_stat()); end
    endtask

    task automatic test_overrun();
        logic [7:0] id_a;
        int len_a;
        logic [8*MAXP-1:0] d_a;
        id_a  = 8'($urandom);
        len_a = $urandom_range(1, MAXP);
        fill_random(len_a);
        d_a = model_data(len_a);
        send_frame(id_a, len_a, 1'b0);
        wait_valid();
        n_cmp++;
        if (frame_valid_o !== 1'b1) begin n_fail++; $display("FAIL ovr_first_valid: got %0b want 1", frame_valid_o); end
        fill_random(5);
        send_frame(id_a ^ 8'hFF, 5, 1'b0);
        e_ov++;
        s_ov++;
        idle(20);
        n_cmp++;
        if ({m_fr, m_cs, m_len, m_to, m_ov} !== {e_fr, e_cs, e_len, e_to, e_ov}) begin
            n_fail++;
            $display("FAIL ovr_pulses: got fr=%0d cs=%0d len=%0d to=%0d ov=%0d want %0d %0d %0d %0d %0d", m_fr, m_cs, m_len, m_to, m_ov, e_fr, e_cs, e_len, e_to, e_ov);
        end
        n_cmp++;
        if ({frame_valid_o, frame_id_o, frame_len_o} !== {1'b1, id_a, LW'(len_a)}) begin
            n_fail++;
            $display("FAIL ovr_kept_hdr: got valid=%0b id=%h len=%0d want 1 %h %0d", frame_valid_o, frame_id_o, frame_len_o, id_a, len_a);
        end
        n_cmp++;
        if (frame_data_o !== d_a) begin n_fail++; $display("FAIL ovr_kept_data: got %h want %h", frame_data_o, d_a); end
        do_ack();
        n_cmp++;
        if (frame_valid_o !== 1'b0) begin n_fail++; $display("FAIL ovr_ack_clear: got %0b want 0", frame_valid_o); end
    endtask

    task automatic test_len();
        int len;
        logic [7:0] id;
        send_byte(8'h7E, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        e_len++;
        idle(20);
        n_cmp++;
        if (m_len !== e_len) begin n_fail++; $display("FAIL len_zero: got %0d pulses want %0d", m_len, e_len); end
        send_byte(8'h7E, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h11, 1'b1);
        e_len++;
        idle(20);
        n_cmp++;
        if (m_len !== e_len) begin n_fail++; $display("FAIL len_over: got %0d pulses want %0d", m_len, e_len); end
        len = MAXP;
        id  = 8'($urandom);
        fill_random(len);
        send_frame(id, len, 1'b0);
        wait_valid();
        n_cmp++;
        if ({frame_valid_o, frame_id_o, frame_len_o} !== {1'b1, id, LW'(len)}) begin
            n_fail++;
            $display("FAIL len_recover_hdr: got valid=%0b id=%h len=%0d want 1 %h %0d", frame_valid_o, frame_id_o, frame_len_o, id, len);
        end
        n_cmp++;
        if (frame_data_o !== model_data(len)) begin n_fail++; $display("FAIL len_recover_data: got %h want %h", frame_data_o, model_data(len)); end
        do_ack();
    endtask

    task automatic test_line_errors();
        int w;
        send_byte(8'h7E, 1'b1);
        send_byte(8'h01, 1'b0);
        e_fr++;
        s_fr++;
        idle(20);
        n_cmp++;
        if ({m_fr, m_cs, m_len, m_to, m_ov} !== {e_fr, e_cs, e_len, e_to, e_ov}) begin
            n_fail++;
            $display("FAIL framing_pulses: got fr=%0d cs=%0d len=%0d to=%0d ov=%0d want %0d %0d %0d %0d %0d", m_fr, m_cs, m_len, m_to, m_ov, e_fr, e_cs, e_len, e_to, e_ov);
        end
        fill_random(3);
        send_frame(8'h33, 3, 1'b0);
        wait_valid();
        n_cmp++;
        if ({frame_valid_o, frame_id_o, frame_len_o} !== {1'b1, 8'h33, LW'(3)}) begin
            n_fail++;
            $display("FAIL framing_abort: got valid=%0b id=%h len=%0d want 1 33 3", frame_valid_o, frame_id_o, frame_len_o);
        end
        do_ack();

        fill_random(4);
        send_byte(8'h7E, 1'b1);
        send_byte(8'h44, 1'b1);
        idle(5);
        rx = 1'b0;
        @(posedge clk);
        #1 rx = 1'b1;
        idle(30);
        send_byte(8'h04, 1'b1);
        for (int k = 0; k < 4; k++) send_byte(pl[k], 1'b1);
        send_byte(model_csum(8'h44, 4), 1'b1);
        wait_valid();
        n_cmp++;
        if ({frame_valid_o, frame_id_o, frame_len_o, frame_data_o} !== {1'b1, 8'h44, LW'(4), model_data(4)}) begin
            n_fail++;
            $display("FAIL glitch_frame: got valid=%0b id=%h len=%0d data=%h want 1 44 4 %h", frame_valid_o, frame_id_o, frame_len_o, frame_data_o, model_data(4));
        end
        n_cmp++;
        if ({m_fr, m_cs, m_len, m_to, m_ov} !== {e_fr, e_cs, e_len, e_to, e_ov}) begin
            n_fail++;
            $display("FAIL glitch_pulses: got fr=%0d cs=%0d len=%0d to=%0d ov=%0d want %0d %0d %0d %0d %0d", m_fr, m_cs, m_len, m_to, m_ov, e_fr, e_cs, e_len, e_to, e_ov);
        end
        do_ack();

        send_byte(8'h7E, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        idle(BIT_DIV * (TOB - 2));
        n_cmp++;
        if (m_to !== e_to) begin n_fail++; $display("FAIL timeout_early: got %0d pulses want %0d", m_to, e_to); end
        e_to++;
        s_to++;
        w = 0;
        while (m_to < e_to && w < 200) begin
            @(posedge clk);
            #1;
            w++;
        end
        idle(2);
        n_cmp++;
        if ({m_fr, m_cs, m_len, m_to, m_ov} !== {e_fr, e_cs, e_len, e_to, e_ov}) begin
            n_fail++;
            $display("FAIL timeout_pulses: got fr=%0d cs=%0d len=%0d to=%0d ov=%0d want %0d %0d %0d %0d %0d", m_fr, m_cs, m_len, m_to, m_ov, e_fr, e_cs, e_len, e_to, e_ov);
        end
        n_cmp++;
        if (stat_cnt_o !== model_stat()) begin n_fail++; $display("FAIL timeout_stat: got %h want %h", stat_cnt_o, model_stat()); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] id;
        int len;
        fill_random(6);
        send_frame(8'h5C, 6, 1'b0);
        wait_valid();
        n_cmp++;
        if (frame_valid_o !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre_valid: got %0b want 1", frame_valid_o); end
        send_byte(8'h7E, 1'b1);
        send_byte(8'h21, 1'b1);
        send_byte(8'h05, 1'b1);
        send_byte(8'h99, 1'b1);
        rx = 1'b0;
        idle(20);
        rst = 1'b1;
        #1;
        s_fr = 0;
        s_cs = 0;
        s_to = 0;
        s_ov = 0;
        n_cmp++;
        if ({frame_valid_o, frame_id_o, frame_len_o, frame_data_o, err_frame_o, err_csum_o, err_len_o, err_timeout_o, overrun_o, stat_cnt_o} !== '0) begin
            n_fail++;
            $display("FAIL rstmid_outputs: got valid=%0b id=%h len=%0d data=%h stat=%h, want all zero", frame_valid_o, frame_id_o, frame_len_o, frame_data_o, stat_cnt_o);
        end
        rx = 1'b1;
        idle(4);
        rst = 1'b0;
        idle(4);
        id  = 8'($urandom);
        len = $urandom_range(1, MAXP);
        fill_random(len);
        send_frame(id, len, 1'b0);
        wait_valid();
        n_cmp++;
        if ({frame_valid_o, frame_id_o, frame_len_o, frame_data_o} !== {1'b1, id, LW'(len), model_data(len)}) begin
            n_fail++;
            $display("FAIL rstmid_after: got valid=%0b id=%h len=%0d data=%h want 1 %h %0d %h", frame_valid_o, frame_id_o, frame_len_o, frame_data_o, id, len, model_data(len));
        end
        n_cmp++;
        if (stat_cnt_o !== model_stat()) begin n_fail++; $display("FAIL rstmid_stat: got %h want %h", stat_cnt_o, model_stat()); end
        do_ack();
    endtask

    task automatic test_random();
        logic [7:0] id;
        int len;
        bit bad;
        for (int it = 0; it < 8; it++) begin
            id  = 8'($urandom);
            len = $urandom_range(1, MAXP);
            bad = ($urandom_range(0, 3) == 0);
            fill_random(len);
            send_frame(id, len, bad);
            if (bad) begin
                e_cs++;
                s_cs++;
                idle(20);
                n_cmp++;
                if ({frame_valid_o, m_cs} !== {1'b0, e_cs}) begin
                    n_fail++;
                    $display("FAIL rand_bad_%0d: got valid=%0b csum_pulses=%0d want 0 %0d", it, frame_valid_o, m_cs, e_cs);
                end
            end else begin
                wait_valid();
                n_cmp++;
                if ({frame_valid_o, frame_id_o, frame_len_o, frame_data_o} !== {1'b1, id, LW'(len), model_data(len)}) begin
                    n_fail++;
                    $display("FAIL rand_good_%0d: got valid=%0b id=%h len=%0d data=%h want 1 %h %0d %h", it, frame_valid_o, frame_id_o, frame_len_o, frame_data_o, id, len, model_data(len));
                end
                do_ack();
                n_cmp++;
                if (frame_valid_o !== 1'b0) begin n_fail++; $display("FAIL rand_ack_%0d: got %0b want 0", it, frame_valid_o); end
            end
        end
    endtask

    task automatic test_stats();
        idle(5);
        n_cmp++;
        if ({m_fr, m_cs, m_len, m_to, m_ov} !== {e_fr, e_cs, e_len, e_to, e_ov}) begin
            n_fail++;
            $display("FAIL final_pulses: got fr=%0d cs=%0d len=%0d to=%0d ov=%0d want %0d %0d %0d %0d %0d", m_fr, m_cs, m_len, m_to, m_ov, e_fr, e_cs, e_len, e_to, e_ov);
        end
        n_cmp++;
        if (stat_cnt_o !== model_stat()) begin n_fail++; $display("FAIL final_stat: got %h want %h", stat_cnt_o, model_stat()); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_csum();
        test_overrun();
        test_len();
        test_line_errors();
        test_reset_mid();
        test_random();
        test_stats();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
